// File: rtl/lc3_reg_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : lc3_pkg
//  Description : Shared definitions for the LC-3 register-file sequencer:
//                opcode constants, FSM state encoding and the default
//                condition-code reset value.
//  Revision    : 1.0  initial release
// ============================================================================
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // Z set after reset
  localparam logic [2:0] NZP_RESET_DEF = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_READ    = 3'd2,
    S_WAIT_WB = 3'd3,
    S_SETUP   = 3'd4,
    S_PULSE   = 3'd5,
    S_HOLD    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lc3_reg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : lc3_reg_sequencer_if
//  Description : Bundles the control-side request, writeback and register-file
//                signals of the LC-3 register sequencer.
//                master : control FSM / datapath / register file side
//                slave  : the sequencer itself
//  Signals     : start, ir, wb_valid, wb_data, rf_out1, rf_out2   (to seq)
//                rf_sr1, rf_sr2, rf_dr, rf_in, rf_load, op_a, op_b,
//                op_valid, nzp, busy, done                       (from seq)
//  Revision    : 1.0  initial release
// ============================================================================
interface lc3_reg_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              start;
  logic [15:0]       ir;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rf_out1;
  logic [DATA_W-1:0] rf_out2;
  logic [REG_AW-1:0] rf_sr1;
  logic [REG_AW-1:0] rf_sr2;
  logic [REG_AW-1:0] rf_dr;
  logic [DATA_W-1:0] rf_in;
  logic              rf_load;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_valid;
  logic [2:0]        nzp;
  logic              busy;
  logic              done;

  modport master (
    output start, ir, wb_valid, wb_data, rf_out1, rf_out2,
    input  rf_sr1, rf_sr2, rf_dr, rf_in, rf_load, op_a, op_b, op_valid,
           nzp, busy, done
  );

  modport slave (
    input  start, ir, wb_valid, wb_data, rf_out1, rf_out2,
    output rf_sr1, rf_sr2, rf_dr, rf_in, rf_load, op_a, op_b, op_valid,
           nzp, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/lc3_reg_sequencer_field_decode.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_field_decode
//  Description : Combinational field decode of an LC-3 instruction word into
//                register addresses and per-opcode control flags.
//  Ports       : i_ir        instruction word
//                o_sr1/o_sr2 source register addresses
//                o_dr        destination register address
//                o_wr_en     opcode writes a register
//                o_cc_en     opcode updates NZP
//                o_imm_sel   op_b comes from imm5 instead of sr2
//                o_imm5_sext sign-extended ir[4:0]
//  Config      : LC3_LINK_R7_EN - JSR/JSRR/TRAP write the link PC to R7
//  Revision    : 1.0  initial release
// ============================================================================
module lc3_field_decode
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  wire logic [15:0]       i_ir,
  output logic      [2:0]        o_sr1,
  output logic      [2:0]        o_sr2,
  output logic      [2:0]        o_dr,
  output logic                   o_wr_en,
  output logic                   o_cc_en,
  output logic                   o_imm_sel,
  output logic      [DATA_W-1:0] o_imm5_sext
);

  logic [3:0] w_opc;
  assign w_opc = i_ir[15:12];

  always_comb begin
    o_sr1   = i_ir[8:6];
    o_sr2   = i_ir[2:0];
    o_dr    = i_ir[11:9];
    o_wr_en = 1'b0;
    o_cc_en = 1'b0;
    case (w_opc)
      // stores read the data register through the sr1 port
      OP_ST, OP_STI, OP_STR: o_sr1 = i_ir[11:9];
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDI, OP_LDR: begin
        o_wr_en = 1'b1;
        o_cc_en = 1'b1;
      end
      OP_LEA: o_wr_en = 1'b1;
      OP_JSR, OP_TRAP: begin
        o_dr = 3'd7;
`ifdef LC3_LINK_R7_EN
        o_wr_en = 1'b1;
`else
        o_wr_en = 1'b0;
`endif
      end
      OP_BR, OP_RTI, OP_JMP, OP_RES: ;
      default: ;
    endcase
  end

  assign o_imm_sel   = ((w_opc == OP_ADD) || (w_opc == OP_AND)) && i_ir[5];
  assign o_imm5_sext = {{(DATA_W-5){i_ir[4]}}, i_ir[4:0]};

endmodule
`default_nettype wire

// File: rtl/lc3_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_reg_sequencer
//  Description : Initiator side of the LC-3 register-file port. Decodes the
//                instruction accepted with start, reads the operands, accepts
//                one writeback word and produces a single-cycle write strobe
//                framed by a setup and a hold cycle. Updates NZP.
//  Ports       : clk    system clock, rising edge
//                reset  asynchronous active-high reset
//                bus    lc3_reg_sequencer_if.slave (request, writeback,
//                       register-file and status signals)
//  Config      : LC3_LINK_R7_EN - JSR/JSRR/TRAP wait for the link PC and write
//                it to R7 (NZP unchanged); otherwise they complete without a
//                write.
//  Revision    : 1.0  initial release
// ============================================================================
module lc3_reg_sequencer
  import lc3_pkg::*;
#(
  parameter int         DATA_W    = 16,
  parameter int         REG_AW    = 3,
  parameter logic [2:0] NZP_RESET = NZP_RESET_DEF
) (
  input wire logic             clk,
  input wire logic             reset,
  lc3_reg_sequencer_if.slave   bus
);

  logic [2:0]        w_sr1, w_sr2, w_dr;
  logic              w_wr_en, w_cc_en, w_imm_sel;
  logic [DATA_W-1:0] w_imm5_sext;
  logic [2:0]        w_nzp;

  state_t            r_state;
  logic              r_wr_en;
  logic              r_cc_en;
  logic              r_imm_sel;
  logic [DATA_W-1:0] r_imm;

  lc3_field_decode #(.DATA_W(DATA_W)) u_decode (
    .i_ir        (bus.ir),
    .o_sr1       (w_sr1),
    .o_sr2       (w_sr2),
    .o_dr        (w_dr),
    .o_wr_en     (w_wr_en),
    .o_cc_en     (w_cc_en),
    .o_imm_sel   (w_imm_sel),
    .o_imm5_sext (w_imm5_sext)
  );

  assign w_nzp = bus.rf_in[DATA_W-1]  ? 3'b100 :
                 (bus.rf_in == '0)    ? 3'b010 : 3'b001;

  // Decode results are captured on the accepting edge so the register file
  // sees stable addresses during DECODE and the ir input is free afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_en      <= 1'b0;
      r_cc_en      <= 1'b0;
      r_imm_sel    <= 1'b0;
      r_imm        <= '0;
      bus.rf_sr1   <= '0;
      bus.rf_sr2   <= '0;
      bus.rf_dr    <= '0;
      bus.rf_in    <= '0;
      bus.rf_load  <= 1'b0;
      bus.op_a     <= '0;
      bus.op_b     <= '0;
      bus.op_valid <= 1'b0;
      bus.nzp      <= NZP_RESET;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.op_valid <= 1'b0;
      bus.rf_load  <= 1'b0;
      bus.done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_DECODE;
            bus.busy   <= 1'b1;
            bus.rf_sr1 <= REG_AW'(w_sr1);
            bus.rf_sr2 <= REG_AW'(w_sr2);
            bus.rf_dr  <= REG_AW'(w_dr);
            r_wr_en    <= w_wr_en;
            r_cc_en    <= w_cc_en;
            r_imm_sel  <= w_imm_sel;
            r_imm      <= w_imm5_sext;
          end
        end
        S_DECODE: begin
          r_state      <= S_READ;
          bus.op_a     <= bus.rf_out1;
          bus.op_b     <= r_imm_sel ? r_imm : bus.rf_out2;
          bus.op_valid <= 1'b1;
        end
        S_READ: begin
          if (r_wr_en) begin
            r_state <= S_WAIT_WB;
          end else begin
            r_state  <= S_DONE;
            bus.done <= 1'b1;
          end
        end
        S_WAIT_WB: begin
          if (bus.wb_valid) begin
            r_state   <= S_SETUP;
            bus.rf_in <= bus.wb_data;
          end
        end
        S_SETUP: begin
          r_state     <= S_PULSE;
          bus.rf_load <= 1'b1;
        end
        S_PULSE: begin
          r_state <= S_HOLD;
          if (r_cc_en) bus.nzp <= w_nzp;
        end
        S_HOLD: begin
          r_state  <= S_DONE;
          bus.done <= 1'b1;
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lc3_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_reg_sequencer
//  Description : Self-checking bench for lc3_reg_sequencer. A behavioural
//                register file answers the read ports; a reference model
//                computes expected fields, operands, write and NZP results
//                from the instruction set rules.
//  Config      : LC3_LINK_R7_EN changes the expected JSR/TRAP behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lc3_reg_sequencer;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  lc3_reg_sequencer_if #(.DATA_W(16), .REG_AW(3)) ifc ();

  lc3_reg_sequencer #(.DATA_W(16), .REG_AW(3), .NZP_RESET(3'b010)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural register file (level-sensitive write sampled at the edge)
  logic [15:0] env_regs [8];
  logic [15:0] exp_regs [8];
  logic [2:0]  exp_nzp;
  logic        pre_we;
  logic [2:0]  pre_idx;
  logic [15:0] pre_val;

  always @(posedge clk) begin
    if (ifc.rf_load)  env_regs[ifc.rf_dr] <= ifc.rf_in;
    else if (pre_we)  env_regs[pre_idx]   <= pre_val;
  end

  assign ifc.rf_out1 = env_regs[ifc.rf_sr1];
  assign ifc.rf_out2 = env_regs[ifc.rf_sr2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input int idx, input logic [15:0] val);
    @(posedge clk); #1;
    pre_we  = 1'b1;
    pre_idx = 3'(idx);
    pre_val = val;
    @(posedge clk); #1;
    pre_we  = 1'b0;
    exp_regs[idx] = val;
  endtask

  function automatic logic [2:0] nzp_model(input logic [15:0] v);
    if ($signed(v) < 0)  return 3'b100;
    if (v == 16'd0)      return 3'b010;
    return 3'b001;
  endfunction

  // One full instruction: start in cycle t, optional ignored starts and an
  // early wb_valid, 'delay' idle cycles in writeback wait, then wb_data.
  task automatic run_op(input logic [15:0] ir, input logic [15:0] wbd,
                        input int delay, input bit ghost, input bit early);
    int          opc, esr1, esr2, edr, v;
    bit          wr, cc;
    logic [15:0] ea, eb;
    opc  = int'(ir[15:12]);
    esr1 = (opc == 3 || opc == 11 || opc == 7) ? int'(ir[11:9]) : int'(ir[8:6]);
    esr2 = int'(ir[2:0]);
    edr  = (opc == 4 || opc == 15) ? 7 : int'(ir[11:9]);
    wr   = (opc inside {1, 5, 9, 2, 10, 6, 14});
`ifdef LC3_LINK_R7_EN
    if (opc == 4 || opc == 15) wr = 1'b1;
`endif
    cc   = (opc inside {1, 5, 9, 2, 10, 6});
    ea   = exp_regs[esr1];
    if ((opc == 1 || opc == 5) && ir[5]) begin
      v = int'(ir[4:0]);
      if (v > 15) v = v - 32;
      eb = 16'(v);
    end else begin
      eb = exp_regs[esr2];
    end

    // cycle t
    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.ir    = ir;
    @(negedge clk);
    check("idle_busy", 32'(ifc.busy), 0);
    // cycle t+1
    @(posedge clk); #1;
    ifc.start = ghost;
    ifc.ir    = 16'($urandom);
    @(negedge clk);
    check("busy", 32'(ifc.busy), 1);
    check("sr1", 32'(ifc.rf_sr1), esr1);
    check("sr2", 32'(ifc.rf_sr2), esr2);
    // cycle t+2
    @(posedge clk); #1;
    ifc.start    = ghost;
    ifc.wb_valid = early;
    ifc.wb_data  = 16'($urandom);
    @(negedge clk);
    check("op_valid", 32'(ifc.op_valid), 1);
    check("op_a", 32'(ifc.op_a), 32'(ea));
    check("op_b", 32'(ifc.op_b), 32'(eb));
    // cycle t+3
    @(posedge clk); #1;
    ifc.start    = 1'b0;
    ifc.wb_valid = 1'b0;
    if (!wr) begin
      @(negedge clk);
      check("nw_done", 32'(ifc.done), 1);
      check("nw_load", 32'(ifc.rf_load), 0);
      check("nw_nzp", 32'(ifc.nzp), 32'(exp_nzp));
    end else begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        check("wait_load", 32'(ifc.rf_load), 0);
        check("wait_done", 32'(ifc.done), 0);
        @(posedge clk); #1;
      end
      // cycle w
      ifc.wb_valid = 1'b1;
      ifc.wb_data  = wbd;
      @(negedge clk);
      check("w_load", 32'(ifc.rf_load), 0);
      // cycle w+1 (SETUP)
      @(posedge clk); #1;
      ifc.wb_valid = 1'b0;
      ifc.wb_data  = 16'($urandom);
      @(negedge clk);
      check("setup_load", 32'(ifc.rf_load), 0);
      check("setup_in", 32'(ifc.rf_in), 32'(wbd));
      check("setup_dr", 32'(ifc.rf_dr), edr);
      // cycle w+2 (PULSE)
      @(posedge clk); #1;
      @(negedge clk);
      check("pulse_load", 32'(ifc.rf_load), 1);
      check("pulse_dr", 32'(ifc.rf_dr), edr);
      check("pulse_in", 32'(ifc.rf_in), 32'(wbd));
      exp_regs[edr] = wbd;
      if (cc) exp_nzp = nzp_model(wbd);
      // cycle w+3 (HOLD)
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_load", 32'(ifc.rf_load), 0);
      check("hold_in", 32'(ifc.rf_in), 32'(wbd));
      check("nzp", 32'(ifc.nzp), 32'(exp_nzp));
      // cycle w+4 (DONE)
      @(posedge clk); #1;
      @(negedge clk);
      check("wr_done", 32'(ifc.done), 1);
      check("rf_written", 32'(env_regs[edr]), 32'(wbd));
    end
  endtask

  initial begin
    reset        = 1'b1;
    ifc.start    = 1'b0;
    ifc.ir       = 16'h0;
    ifc.wb_valid = 1'b0;
    ifc.wb_data  = 16'h0;
    pre_we       = 1'b0;
    pre_idx      = 3'd0;
    pre_val      = 16'h0;
    exp_nzp      = 3'b010;
    for (int i = 0; i < 8; i++) begin
      env_regs[i] = 16'h0;
      exp_regs[i] = 16'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(ifc.busy), 0);
    check("rst_load", 32'(ifc.rf_load), 0);
    check("rst_opv", 32'(ifc.op_valid), 0);
    check("rst_done", 32'(ifc.done), 0);
    check("rst_nzp", 32'(ifc.nzp), 32'h2);
    check("rst_opa", 32'(ifc.op_a), 0);
    check("rst_sr1", 32'(ifc.rf_sr1), 0);
    check("rst_in", 32'(ifc.rf_in), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) preload(i, 16'($urandom));
    preload(2, 16'd5);
    preload(3, 16'd7);

    run_op(16'h1283, 16'd12,   1,  1'b0, 1'b0);  // ADD R1,R2,R3
    run_op(16'h54BF, 16'h8000, 0,  1'b0, 1'b0);  // AND R2,R2,#-1
    run_op(16'h3E05, 16'h1234, 0,  1'b1, 1'b0);  // ST R7 with start while busy
    run_op(16'h4800, 16'h3001, 2,  1'b0, 1'b0);  // JSR
    run_op(16'h1283, 16'h0000, 10, 1'b0, 1'b1);  // early wb_valid, long wait

    for (int n = 0; n < 40; n++) begin
      logic [15:0] rir, rwb;
      rir = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rwb = 16'h0000;
        1:       rwb = 16'h8000 | 16'($urandom);
        default: rwb = 16'($urandom);
      endcase
      run_op(rir, rwb, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    // set N, then reset in the middle of the write strobe
    run_op(16'h54BF, 16'h8001, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.ir    = 16'h1283;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifc.wb_valid = 1'b1;
    ifc.wb_data  = 16'h0005;
    @(posedge clk); #1;
    ifc.wb_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_load", 32'(ifc.rf_load), 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_load", 32'(ifc.rf_load), 0);
    check("mid_rst_busy", 32'(ifc.busy), 0);
    check("mid_rst_nzp", 32'(ifc.nzp), 32'h2);
    check("mid_rst_done", 32'(ifc.done), 0);
    exp_nzp = 3'b010;
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(16'h1283, 16'h0042, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
